// File: rtl/bp_dma_link_edge_adapter.sv
// ---------------------------------------------------------------------------
// bp_dma_link_edge_adapter
//
// Terminates one DMA ready-and wormhole link at the south edge of the memory
// complex. The RX path gathers a header flit plus its payload flits into one
// wide parallel packet. The TX path serializes a wide response packet back
// onto the link. RX and TX are independent state machines with independent
// flow control; they only share the packed link_o bus.
//
// Ports
//   clk_i               clock
//   reset_n_i           asynchronous active-low reset
//   link_i              incoming link {v, data, ready_and_rev}
//   link_o              outgoing link {v, data, ready_and_rev}
//   rx_pkt_o            assembled packet, flit k at [k*flit_width_p +: flit_width_p]
//   rx_pkt_v_o          assembled packet valid
//   rx_pkt_ready_and_i  consumer accepts the assembled packet
//   tx_pkt_i            packet to serialize, same layout as rx_pkt_o
//   tx_pkt_v_i          tx_pkt_i valid
//   tx_pkt_ready_and_o  TX path can accept a packet
//   err_o               sticky: an RX header announced more payload than fits
// ---------------------------------------------------------------------------
module bp_dma_link_edge_adapter #(
  parameter  int flit_width_p        = 64,
  parameter  int len_width_p         = 4,
  parameter  int max_payload_flits_p = 8,
  localparam int pkt_width_lp        = flit_width_p * (max_payload_flits_p + 1),
  localparam int link_width_lp       = flit_width_p + 2
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [link_width_lp-1:0] link_i,
  output logic [link_width_lp-1:0] link_o,
  output logic [pkt_width_lp-1:0]  rx_pkt_o,
  output logic                     rx_pkt_v_o,
  input  logic                     rx_pkt_ready_and_i,
  input  logic [pkt_width_lp-1:0]  tx_pkt_i,
  input  logic                     tx_pkt_v_i,
  output logic                     tx_pkt_ready_and_o,
  output logic                     err_o
);

  localparam int slots_lp = max_payload_flits_p + 1;

  typedef enum logic [1:0] {
    RX_HDR  = 2'd0,
    RX_BODY = 2'd1,
    RX_OUT  = 2'd2
  } rx_state_e;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

  // Saturate a header length to what the wide packet can actually hold.
  function automatic logic [len_width_p-1:0] clamp_len(input logic [len_width_p-1:0] len);
    if (int'(len) > max_payload_flits_p) begin
      return len_width_p'(max_payload_flits_p);
    end
    return len;
  endfunction

  // Incoming link fields
  logic                    link_v_li;
  logic [flit_width_p-1:0] link_data_li;
  logic                    link_ready_li;

  assign link_v_li     = link_i[link_width_lp-1];
  assign link_data_li  = link_i[flit_width_p:1];
  assign link_ready_li = link_i[0];

  // State
  rx_state_e               rx_state_q, rx_state_d;
  logic [pkt_width_lp-1:0] rx_pkt_q,   rx_pkt_d;
  logic [len_width_p-1:0]  rx_len_q,   rx_len_d;
  logic [len_width_p-1:0]  rx_cnt_q,   rx_cnt_d;
  logic                    err_q,      err_d;

  tx_state_e               tx_state_q, tx_state_d;
  logic [pkt_width_lp-1:0] tx_pkt_q,   tx_pkt_d;
  logic [len_width_p-1:0]  tx_len_q,   tx_len_d;
  logic [len_width_p-1:0]  tx_idx_q,   tx_idx_d;

  // Low during reset and for the release edge, so that no ready output is
  // asserted while reset_n_i is low; high from the first clock edge on.
  logic                    run_q,      run_d;

  logic                    rx_ready;
  logic                    rx_xfer;
  logic [len_width_p-1:0]  hdr_len;
  logic                    tx_ready;
  logic                    tx_accept;
  logic [flit_width_p-1:0] tx_flit;
  logic                    link_v_lo;
  logic [flit_width_p-1:0] link_data_lo;

  assign run_d     = 1'b1;
  assign rx_ready  = run_q & (rx_state_q != RX_OUT);
  assign rx_xfer   = link_v_li & rx_ready;
  assign hdr_len   = link_data_li[len_width_p-1:0];
  assign tx_ready  = run_q & (tx_state_q == TX_IDLE);
  assign tx_accept = tx_pkt_v_i & tx_ready;

  // RX: header / body collection / hand-off
  always_comb begin
    rx_state_d = rx_state_q;
    rx_pkt_d   = rx_pkt_q;
    rx_len_d   = rx_len_q;
    rx_cnt_d   = rx_cnt_q;
    err_d      = err_q;

    unique case (rx_state_q)
      RX_HDR: begin
        if (rx_xfer) begin
          rx_pkt_d                     = '0;
          rx_pkt_d[flit_width_p-1:0]   = link_data_li;
          rx_len_d                     = hdr_len;
          rx_cnt_d                     = '0;
          rx_state_d                   = (hdr_len == '0) ? RX_OUT : RX_BODY;
          if (int'(hdr_len) > max_payload_flits_p) begin
            err_d = 1'b1;
          end
        end
      end

      RX_BODY: begin
        if (rx_xfer) begin
          // Flits beyond the buffer match no slot and are dropped; the link
          // keeps flowing so the oversize packet is still fully drained.
          for (int s = 1; s < slots_lp; s++) begin
            if (int'(rx_cnt_q) + 1 == s) begin
              rx_pkt_d[s*flit_width_p +: flit_width_p] = link_data_li;
            end
          end
          rx_cnt_d = rx_cnt_q + len_width_p'(1);
          if (rx_cnt_q == rx_len_q - len_width_p'(1)) begin
            rx_state_d = RX_OUT;
          end
        end
      end

      RX_OUT: begin
        if (rx_pkt_ready_and_i) begin
          rx_state_d = RX_HDR;
        end
      end

      default: rx_state_d = RX_HDR;
    endcase
  end

  // TX: accept / serialize
  always_comb begin
    tx_state_d = tx_state_q;
    tx_pkt_d   = tx_pkt_q;
    tx_len_d   = tx_len_q;
    tx_idx_d   = tx_idx_q;

    unique case (tx_state_q)
      TX_IDLE: begin
        if (tx_accept) begin
          tx_pkt_d   = tx_pkt_i;
          tx_len_d   = clamp_len(tx_pkt_i[len_width_p-1:0]);
          tx_idx_d   = '0;
          tx_state_d = TX_SEND;
        end
      end

      TX_SEND: begin
        if (link_ready_li) begin
          tx_idx_d = tx_idx_q + len_width_p'(1);
          if (tx_idx_q == tx_len_q) begin
            tx_state_d = TX_IDLE;
          end
        end
      end

      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Flit select for the outgoing link; idx never exceeds the clamped length.
  always_comb begin
    tx_flit = '0;
    for (int s = 0; s < slots_lp; s++) begin
      if (int'(tx_idx_q) == s) begin
        tx_flit = tx_pkt_q[s*flit_width_p +: flit_width_p];
      end
    end
  end

  assign link_v_lo    = (tx_state_q == TX_SEND);
  assign link_data_lo = link_v_lo ? tx_flit : '0;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      run_q      <= 1'b0;
      rx_state_q <= RX_HDR;
      rx_pkt_q   <= '0;
      rx_len_q   <= '0;
      rx_cnt_q   <= '0;
      err_q      <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_pkt_q   <= '0;
      tx_len_q   <= '0;
      tx_idx_q   <= '0;
    end else begin
      run_q      <= run_d;
      rx_state_q <= rx_state_d;
      rx_pkt_q   <= rx_pkt_d;
      rx_len_q   <= rx_len_d;
      rx_cnt_q   <= rx_cnt_d;
      err_q      <= err_d;
      tx_state_q <= tx_state_d;
      tx_pkt_q   <= tx_pkt_d;
      tx_len_q   <= tx_len_d;
      tx_idx_q   <= tx_idx_d;
    end
  end

  assign link_o             = {link_v_lo, link_data_lo, rx_ready};
  assign rx_pkt_o           = rx_pkt_q;
  assign rx_pkt_v_o         = (rx_state_q == RX_OUT);
  assign tx_pkt_ready_and_o = tx_ready;
  assign err_o              = err_q;

endmodule
